// File: rtl/complex_accum_stream_pkg.sv
// -----------------------------------------------------------------------------
// complex_accum_stream_pkg
//   Shared definitions for the streaming complex accumulator: the clog2 helper,
//   derived-width helpers (ACC_W, LEN_W), default parameter values and the
//   frame state encoding.
// -----------------------------------------------------------------------------
package complex_accum_stream_pkg;

    localparam int DEF_QI        = 4;
    localparam int DEF_QF        = 4;
    localparam int DEF_MAX_TERMS = 8;
    localparam int DEF_OUT_W     = 10;
    localparam int DEF_SAT       = 1;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

    // Accumulator width: a sum of max_terms samples can never overflow it.
    function automatic int acc_width(input int qi, input int qf, input int max_terms);
        return qi + qf + clog2(max_terms);
    endfunction

    // Width of the len port: must be able to express 0..max_terms.
    function automatic int len_width(input int max_terms);
        return clog2(max_terms + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/complex_accum_stream_sat_narrow.sv
// -----------------------------------------------------------------------------
// sat_narrow
//   Combinational narrowing of a signed IN_W value to OUT_W bits (same binary
//   point). Out-of-range values are clamped (SAT=1) or wrapped to the low
//   OUT_W bits (SAT=0); ovf_o flags any value outside the OUT_W range.
//   Ports:
//     val_i  in  IN_W   signed wide value
//     val_o  out OUT_W  signed narrowed value
//     ovf_o  out 1      val_i did not fit OUT_W
// -----------------------------------------------------------------------------
module sat_narrow #(
    parameter int IN_W  = 11,
    parameter int OUT_W = 10,
    parameter int SAT   = 1
) (
    input  logic [IN_W-1:0]  val_i,
    output logic [OUT_W-1:0] val_o,
    output logic             ovf_o
);

    // Representable bounds of an OUT_W signed value, expressed in IN_W bits.
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] val_s;
    assign val_s = $signed(val_i);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        ovf_o = 1'b0;
        val_o = val_i[OUT_W-1:0];
        if (val_s > MAX_V) begin
            ovf_o = 1'b1;
            if (SAT != 0) val_o = MAX_V[OUT_W-1:0];
        end else if (val_s < MIN_V) begin
            ovf_o = 1'b1;
            if (SAT != 0) val_o = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/complex_accum_stream.sv
// -----------------------------------------------------------------------------
// complex_accum_stream
//   Accumulates 1..MAX_TERMS signed QI.QF complex samples into one complex sum,
//   one sample per clock, and presents it narrowed to OUT_W bits.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     input handshake (beat = in_valid & in_ready)
//     in_re, in_im          signed W-bit sample
//     len                   terms in the frame, sampled on the first beat
//     out_valid/out_ready   output handshake
//     out_re, out_im        signed OUT_W-bit result
//     overflow              current result did not fit OUT_W
//     ovf_sticky            OR of overflows since reset / sticky_clr
//     sticky_clr            synchronous clear of ovf_sticky (a set wins)
// -----------------------------------------------------------------------------
module complex_accum_stream
    import complex_accum_stream_pkg::*;
#(
    parameter int QI        = DEF_QI,
    parameter int QF        = DEF_QF,
    parameter int MAX_TERMS = DEF_MAX_TERMS,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SAT       = DEF_SAT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [QI+QF-1:0]                  in_re,
    input  logic [QI+QF-1:0]                  in_im,
    input  logic [len_width(MAX_TERMS)-1:0]   len,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_W-1:0]                  out_re,
    output logic [OUT_W-1:0]                  out_im,
    output logic                              overflow,
    output logic                              ovf_sticky,
    input  logic                              sticky_clr
);

    localparam int W     = QI + QF;
    localparam int ACC_W = acc_width(QI, QF, MAX_TERMS);
    localparam int LEN_W = len_width(MAX_TERMS);

    state_e                    state_q, state_d;
    logic                      rdy_q;
    logic signed [ACC_W-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d, len_q, len_d;
    logic [OUT_W-1:0]          out_re_q, out_im_q;
    logic                      ovf_q, sticky_q;

    logic signed [ACC_W-1:0]   smp_re, smp_im;
    logic [LEN_W-1:0]          len_clamped;
    logic                      beat, enter_hold;
    logic [OUT_W-1:0]          nar_re, nar_im;
    logic                      ovf_re, ovf_im;

    assign smp_re = ACC_W'($signed(in_re));
    assign smp_im = ACC_W'($signed(in_im));
    assign beat   = in_valid & rdy_q;

    // A length of 0 means a single term; anything above MAX_TERMS saturates.
    always_comb begin
        len_clamped = len;
        if (len == '0) begin
            len_clamped = LEN_W'(1);
        end else if (len > LEN_W'(MAX_TERMS)) begin
            len_clamped = LEN_W'(MAX_TERMS);
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    len_d    = len_clamped;
                    acc_re_d = smp_re;
                    acc_im_d = smp_im;
                    cnt_d    = LEN_W'(1);
                    state_d  = (len_clamped == LEN_W'(1)) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_re_d = acc_re_q + smp_re;
                    acc_im_d = acc_im_q + smp_im;
                    cnt_d    = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The narrowers look at the next-state sum so the result can be registered
    // on the same edge that accepts the final beat.
    assign enter_hold = (state_d == HOLD) && (state_q != HOLD);

    sat_narrow #(.IN_W(ACC_W), .OUT_W(OUT_W), .SAT(SAT)) u_narrow_re (
        .val_i (acc_re_d),
        .val_o (nar_re),
        .ovf_o (ovf_re)
    );

    sat_narrow #(.IN_W(ACC_W), .OUT_W(OUT_W), .SAT(SAT)) u_narrow_im (
        .val_i (acc_im_d),
        .val_o (nar_im),
        .ovf_o (ovf_im)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rdy_q    <= 1'b0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Registered so in_ready stays low through reset and rises on the
            // first clock after release.
            rdy_q    <= (state_d != HOLD);
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            if (enter_hold) begin
                out_re_q <= nar_re;
                out_im_q <= nar_im;
                ovf_q    <= ovf_re | ovf_im;
            end
            if (enter_hold && (ovf_re | ovf_im)) begin
                sticky_q <= 1'b1;
            end else if (sticky_clr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (state_q == HOLD);
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign overflow   = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_complex_accum_stream.sv
// -----------------------------------------------------------------------------
// tb_complex_accum_stream
//   Drives a clamping (SAT=1) and a wrapping (SAT=0) instance with the same
//   stream and compares both against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_complex_accum_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       sticky_clr = 1'b0;
    logic [7:0] in_re = '0;
    logic [7:0] in_im = '0;
    logic [3:0] len = '0;

    logic       s_in_ready, s_out_valid, s_ovf, s_sticky;
    logic [9:0] s_out_re, s_out_im;
    logic       w_in_ready, w_out_valid, w_ovf, w_sticky;
    logic [9:0] w_out_re, w_out_im;

    always #5 clk = ~clk;

    complex_accum_stream #(.QI(4), .QF(4), .MAX_TERMS(8), .OUT_W(10), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_re(in_re), .in_im(in_im), .len(len), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_re(s_out_re), .out_im(s_out_im),
        .overflow(s_ovf), .ovf_sticky(s_sticky), .sticky_clr(sticky_clr)
    );

    complex_accum_stream #(.QI(4), .QF(4), .MAX_TERMS(8), .OUT_W(10), .SAT(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_re(in_re), .in_im(in_im), .len(len), .out_valid(w_out_valid),
        .out_ready(out_ready), .out_re(w_out_re), .out_im(w_out_im),
        .overflow(w_ovf), .ovf_sticky(w_sticky), .sticky_clr(sticky_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int smp_re[16];
    int smp_im[16];
    int e_re_s, e_im_s, e_re_w, e_im_w;
    bit e_ovf;
    bit sticky_m = 1'b0;
    int early_valid;

    // ---------------- reference model ----------------
    function automatic int clamp_len(input int l);
        if (l == 0) return 1;
        if (l > 8) return 8;
        return l;
    endfunction

    function automatic int wrap10(input int v);
        int m;
        m = ((v % 1024) + 1024) % 1024;
        return (m >= 512) ? m - 1024 : m;
    endfunction

    task automatic narrow(input int v, input bit sat, output int o, output bit ovf);
        ovf = (v > 511) || (v < -512);
        if (!ovf)      o = v;
        else if (!sat) o = wrap10(v);
        else           o = (v > 0) ? 511 : -512;
    endtask

    task automatic compute_expected(input int n);
        int sr, si;
        bit o1, o2, o3, o4;
        sr = 0;
        si = 0;
        for (int i = 0; i < n; i++) begin
            sr += smp_re[i];
            si += smp_im[i];
        end
        narrow(sr, 1'b1, e_re_s, o1);
        narrow(si, 1'b1, e_im_s, o2);
        narrow(sr, 1'b0, e_re_w, o3);
        narrow(si, 1'b0, e_im_w, o4);
        e_ovf = o1 | o2;
    endtask

    // ---------------- stimulus drivers (no checking) ----------------
    task automatic drive_frame(input int len_v, input int n, input int gap_max, input bit clr_last);
        int g;
        early_valid = 0;
        for (int i = 0; i < n; i++) begin
            in_valid   = 1'b1;
            in_re      = 8'(smp_re[i]);
            in_im      = 8'(smp_im[i]);
            len        = (i == 0) ? 4'(len_v) : 4'($urandom);
            sticky_clr = clr_last && (i == n - 1);
            @(posedge clk); #1;
            in_valid   = 1'b0;
            sticky_clr = 1'b0;
            if (i < n - 1) begin
                if (s_out_valid || w_out_valid) early_valid++;
                g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
                repeat (g) begin
                    @(posedge clk); #1;
                    if (s_out_valid || w_out_valid) early_valid++;
                end
            end
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic rand_samples(input int n);
        for (int i = 0; i < n; i++) begin
            smp_re[i] = int'($urandom_range(0, 255)) - 128;
            smp_im[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({s_in_ready, s_out_valid, s_out_re, s_out_im, s_ovf, s_sticky,
             w_in_ready, w_out_valid, w_out_re, w_out_im, w_ovf, w_sticky} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b re=%0d im=%0d ovf=%0b stk=%0b, expected all 0",
                     s_in_ready, s_out_valid, s_out_re, s_out_im, s_ovf, s_sticky);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({s_in_ready, w_in_ready, s_out_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release_ready: got rdy=%0b/%0b vld=%0b, expected rdy=1/1 vld=0",
                     s_in_ready, w_in_ready, s_out_valid);
        end
    endtask

    task automatic test_frame(input string name, input int len_v, input int gap_max, input bit clr_last);
        drive_frame(len_v, clamp_len(len_v), gap_max, clr_last);
        compute_expected(clamp_len(len_v));
        if (e_ovf) sticky_m = 1'b1;
        else if (clr_last) sticky_m = 1'b0;
        n_tests++;
        if (early_valid != 0) begin
            n_fail++;
            $display("FAIL %s early_valid: got %0d cycles with out_valid before last beat, expected 0", name, early_valid);
        end
        n_tests++;
        if ({s_out_valid, s_ovf, s_sticky, s_out_re, s_out_im} !==
            {1'b1, e_ovf, sticky_m, 10'(e_re_s), 10'(e_im_s)}) begin
            n_fail++;
            $display("FAIL %s sat: got vld=%0b ovf=%0b stk=%0b re=%0d im=%0d, expected vld=1 ovf=%0b stk=%0b re=%0d im=%0d",
                     name, s_out_valid, s_ovf, s_sticky, $signed(s_out_re), $signed(s_out_im),
                     e_ovf, sticky_m, e_re_s, e_im_s);
        end
        n_tests++;
        if ({w_out_valid, w_ovf, w_sticky, w_out_re, w_out_im} !==
            {1'b1, e_ovf, sticky_m, 10'(e_re_w), 10'(e_im_w)}) begin
            n_fail++;
            $display("FAIL %s wrap: got vld=%0b ovf=%0b stk=%0b re=%0d im=%0d, expected vld=1 ovf=%0b stk=%0b re=%0d im=%0d",
                     name, w_out_valid, w_ovf, w_sticky, $signed(w_out_re), $signed(w_out_im),
                     e_ovf, sticky_m, e_re_w, e_im_w);
        end
    endtask

    task automatic test_basic();
        smp_re[0] = 9; smp_im[0] = 3;
        smp_re[1] = 1; smp_im[1] = 6;
        smp_re[2] = 4; smp_im[2] = 3;
        test_frame("basic", 3, 0, 1'b0);
        release_result();
    endtask

    task automatic test_gap();
        smp_re[0] = -3; smp_im[0] = -2;
        smp_re[1] = 1;  smp_im[1] = 1;
        smp_re[2] = -1; smp_im[2] = -1;
        test_frame("gap", 3, 2, 1'b0);
        release_result();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            smp_re[i] = 127;
            smp_im[i] = -128;
        end
        test_frame("overflow", 8, 0, 1'b0);
        release_result();
    endtask

    task automatic test_backpressure();
        logic [9:0] held_re;
        logic [9:0] held_im;
        rand_samples(4);
        test_frame("bp_frame", 4, 1, 1'b0);
        held_re = 10'(e_re_s);
        held_im = 10'(e_im_s);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_re    = 8'($urandom);
            in_im    = 8'($urandom);
            @(posedge clk); #1;
            n_tests++;
            if ({s_out_valid, s_in_ready, w_in_ready, s_out_re, s_out_im} !== {3'b100, held_re, held_im}) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got vld=%0b rdy=%0b/%0b re=%0d im=%0d, expected vld=1 rdy=0/0 re=%0d im=%0d",
                         c, s_out_valid, s_in_ready, w_in_ready, $signed(s_out_re), $signed(s_out_im),
                         $signed(held_re), $signed(held_im));
            end
        end
        in_valid = 1'b0;
        release_result();
        n_tests++;
        if ({s_out_valid, s_in_ready, w_out_valid, w_in_ready} !== 4'b0101) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%0b rdy=%0b wvld=%0b wrdy=%0b, expected vld=0 rdy=1",
                     s_out_valid, s_in_ready, w_out_valid, w_in_ready);
        end
    endtask

    task automatic test_reset_midframe();
        rand_samples(2);
        in_valid = 1'b1;
        len      = 4'd4;
        for (int i = 0; i < 2; i++) begin
            in_re = 8'(smp_re[i]);
            in_im = 8'(smp_im[i]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        sticky_m = 1'b0;
        #1;
        n_tests++;
        if ({s_in_ready, s_out_valid, s_out_re, s_out_im, s_ovf, s_sticky,
             w_in_ready, w_out_valid, w_out_re, w_out_im, w_ovf, w_sticky} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset_outputs: got rdy=%0b vld=%0b re=%0d im=%0d, expected all 0",
                     s_in_ready, s_out_valid, s_out_re, s_out_im);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        smp_re[0] = 5; smp_im[0] = -5;
        test_frame("after_reset", 1, 0, 1'b0);
        release_result();
    endtask

    task automatic test_len_clamp();
        smp_re[0] = 2; smp_im[0] = 2;
        test_frame("len0", 0, 0, 1'b0);
        release_result();
        rand_samples(8);
        test_frame("len15", 15, 1, 1'b0);
        release_result();
    endtask

    task automatic test_sticky();
        for (int i = 0; i < 8; i++) begin
            smp_re[i] = 120;
            smp_im[i] = 3;
        end
        test_frame("sticky_set", 8, 0, 1'b0);
        release_result();
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        sticky_m   = 1'b0;
        n_tests++;
        if ({s_sticky, w_sticky} !== 2'b00) begin
            n_fail++;
            $display("FAIL sticky_clear: got %0b/%0b, expected 0/0", s_sticky, w_sticky);
        end
        test_frame("sticky_clr_vs_set", 8, 0, 1'b1);
        release_result();
        smp_re[0] = 1; smp_im[0] = 1;
        test_frame("sticky_clr_no_ovf", 1, 0, 1'b1);
        release_result();
    endtask

    task automatic test_random();
        int lv;
        for (int f = 0; f < 40; f++) begin
            lv = $urandom_range(0, 15);
            rand_samples(clamp_len(lv));
            test_frame("random", lv, 2, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 release_result();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_overflow();
        test_backpressure();
        test_reset_midframe();
        test_len_clamp();
        test_sticky();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
